// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter
//   Owns one single-port memory bank and shares it between two requesters
//   with round-robin arbitration. After reset the bank is filled with its
//   own word index, one word per cycle, before traffic is accepted.
//
//   Build option: MEM_BANK_ARB_INIT_FILL_EN
//     defined   - INIT writes bank[i] = i for every word (DEPTH cycles).
//     undefined - INIT lasts one cycle, performs no writes, and the fill
//                 counter is not built.
//
// Ports
//   clk                 single clock, rising edge
//   reset_n             asynchronous assert, active-low reset
//   reqN_valid          requester N has a request
//   reqN_write          1 = write, 0 = read
//   reqN_addr           word address
//   reqN_wdata          write data
//   reqN_ready          grant; a transfer happens on valid & ready
//   rspN_valid          one-cycle pulse, the cycle after a read transfer
//   rspN_rdata          registered read data, holds while rspN_valid is low
//   init_done           high once INIT is complete, until the next reset
module mem_bank_arbiter #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 1718,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] bank [0:DEPTH-1];

    state_e                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic                  init_done_q, init_done_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
`ifdef MEM_BANK_ARB_INIT_FILL_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
`endif

    logic                  grant0, grant1, xfer;
    logic                  xfer_write, addr_ok;
    logic [ADDR_WIDTH-1:0] xfer_addr;
    logic [DATA_WIDTH-1:0] xfer_wdata, rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Arbitration: with both requesters valid, rr_last names the requester
    // served most recently, so the other one wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                grant0 = rr_last_q;
                grant1 = !rr_last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        xfer       = grant0 || grant1;
        xfer_write = grant1 ? req1_write : req0_write;
        xfer_addr  = grant1 ? req1_addr  : req0_addr;
        xfer_wdata = grant1 ? req1_wdata : req0_wdata;
        addr_ok    = ({1'b0, xfer_addr} < DEPTH_C);
        rd_word    = '0;
        if (addr_ok) begin
            rd_word = bank[xfer_addr];
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        init_done_d  = init_done_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        mem_we       = 1'b0;
        mem_addr     = xfer_addr;
        mem_wdata    = xfer_wdata;
`ifdef MEM_BANK_ARB_INIT_FILL_EN
        idx_d        = idx_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef MEM_BANK_ARB_INIT_FILL_EN
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = DATA_WIDTH'(idx_q);
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
`else
                state_d     = ST_RUN;
                init_done_d = 1'b1;
`endif
            end
            ST_RUN: begin
                if (xfer) begin
                    rr_last_d = grant1;
                    if (xfer_write) begin
                        // Out-of-range writes complete the handshake but
                        // leave the bank untouched.
                        mem_we = addr_ok;
                    end else if (grant0) begin
                        rsp0_valid_d = 1'b1;
                        rsp0_rdata_d = rd_word;
                    end else begin
                        rsp1_valid_d = 1'b1;
                        rsp1_rdata_d = rd_word;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            rr_last_q    <= 1'b1;
            init_done_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifdef MEM_BANK_ARB_INIT_FILL_EN
            idx_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            init_done_q  <= init_done_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
`ifdef MEM_BANK_ARB_INIT_FILL_EN
            idx_q        <= idx_d;
`endif
        end
    end

    // Bank has no reset; writes are suppressed while reset is held so the
    // contents survive a reset untouched.
    always_ff @(posedge clk) begin
        if (mem_we && reset_n) begin
            bank[mem_addr] <= mem_wdata;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
module tb_mem_bank_arbiter;

    localparam int DW = 18;
    localparam int AW = 11;
    localparam int DEPTH = 1718;
`ifdef MEM_BANK_ARB_INIT_FILL_EN
    localparam int INIT_CYC = DEPTH;
    localparam logic [DW-1:0] EXP_175_AFTER_RESET = 18'h000AF;
`else
    localparam int INIT_CYC = 1;
    localparam logic [DW-1:0] EXP_175_AFTER_RESET = 18'h3FFFF;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_bank_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .init_done(init_done)
    );

    typedef struct {
        logic          v0, w0, v1, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          rdy0, rdy1, rv0, rv1;
        logic [DW-1:0] rd0, rd1;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(int v0, int w0, int a0, int d0,
                                int v1, int w1, int a1, int d1,
                                int rdy0, int rdy1,
                                int rv0, int rd0, int rv1, int rd1);
        vec_t r;
        r.v0 = 1'(v0);  r.w0 = 1'(w0);  r.a0 = AW'(a0);  r.d0 = DW'(d0);
        r.v1 = 1'(v1);  r.w1 = 1'(w1);  r.a1 = AW'(a1);  r.d1 = DW'(d1);
        r.rdy0 = 1'(rdy0); r.rdy1 = 1'(rdy1);
        r.rv0 = 1'(rv0); r.rd0 = DW'(rd0);
        r.rv1 = 1'(rv1); r.rd1 = DW'(rd1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flags"}, 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done}), 32'd0);
        chk({tag, "_rd0"}, 32'(rsp0_rdata), 32'd0);
        chk({tag, "_rd1"}, 32'(rsp1_rdata), 32'd0);
    endtask

    // Counts rising edges from release until init_done; optionally holds a
    // port-0 write pending throughout INIT to show it is held off.
    task automatic wait_init(input string tag);
        int  cyc;
        logic saw_ready;
        cyc = 0;
        saw_ready = 1'b0;
        while (cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (init_done) break;
            if (req0_ready || req1_ready) saw_ready = 1'b1;
        end
        chk({tag, "_init_cycles"}, 32'(cyc), 32'(INIT_CYC));
        chk({tag, "_ready_in_init"}, 32'(saw_ready), 32'd0);
    endtask

    task automatic do_write(input int port, input int addr, input int data);
        @(negedge clk);
        if (port == 0) begin
            req0_valid = 1'b1; req0_write = 1'b1; req0_addr = AW'(addr); req0_wdata = DW'(data);
        end else begin
            req1_valid = 1'b1; req1_write = 1'b1; req1_addr = AW'(addr); req1_wdata = DW'(data);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_read(input string tag, input int addr, input logic [DW-1:0] exp);
        @(negedge clk);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = AW'(addr);
        #1;
        chk({tag, "_ready"}, 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        chk({tag, "_valid"}, 32'(rsp0_valid), 32'd1);
        chk({tag, "_rdata"}, 32'(rsp0_rdata), 32'(exp));
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, 32'(rsp0_valid), 32'd0);
    endtask

    initial begin
        //            v0 w0 a0    d0        v1 w1 a1    d1        rdy0 rdy1 rv0 rd0       rv1 rd1
        vecs[0]  = mk(1, 0, 1717, 0,        0, 0, 0,    0,        1, 0,  1, 'h006B5, 0, 0);
        vecs[1]  = mk(1, 0, 44,   0,        0, 0, 0,    0,        1, 0,  1, 'h0002C, 0, 0);
        vecs[2]  = mk(0, 0, 0,    0,        0, 0, 0,    0,        0, 0,  0, 'h0002C, 0, 0);
        vecs[3]  = mk(1, 1, 175,  'h3FFFF,  0, 0, 0,    0,        1, 0,  0, 'h0002C, 0, 0);
        vecs[4]  = mk(0, 0, 0,    0,        1, 0, 175,  0,        0, 1,  0, 'h0002C, 1, 'h3FFFF);
        vecs[5]  = mk(1, 0, 10,   0,        1, 0, 20,   0,        1, 0,  1, 'h0000A, 0, 'h3FFFF);
        vecs[6]  = mk(1, 0, 10,   0,        1, 0, 20,   0,        0, 1,  0, 'h0000A, 1, 'h00014);
        vecs[7]  = mk(1, 0, 10,   0,        1, 0, 20,   0,        1, 0,  1, 'h0000A, 0, 'h00014);
        vecs[8]  = mk(1, 0, 10,   0,        1, 0, 20,   0,        0, 1,  0, 'h0000A, 1, 'h00014);
        vecs[9]  = mk(1, 0, 10,   0,        1, 0, 20,   0,        1, 0,  1, 'h0000A, 0, 'h00014);
        vecs[10] = mk(1, 0, 10,   0,        1, 0, 20,   0,        0, 1,  0, 'h0000A, 1, 'h00014);
        vecs[11] = mk(0, 0, 0,    0,        1, 0, 1718, 0,        0, 1,  0, 'h0000A, 1, 0);
        vecs[12] = mk(0, 0, 0,    0,        1, 1, 2000, 'h12345,  0, 1,  0, 'h0000A, 0, 0);
        vecs[13] = mk(0, 0, 0,    0,        1, 0, 1717, 0,        0, 1,  0, 'h0000A, 1, 'h006B5);
        vecs[14] = mk(1, 1, 5,    'h00123,  1, 0, 5,    0,        1, 0,  0, 'h0000A, 0, 'h006B5);
        vecs[15] = mk(0, 0, 0,    0,        1, 0, 5,    0,        0, 1,  0, 'h0000A, 1, 'h00123);
        vecs[16] = mk(1, 0, 2047, 0,        0, 0, 0,    0,        1, 0,  1, 0,         0, 'h00123);
        vecs[17] = mk(0, 0, 0,    0,        1, 0, 2000, 0,        0, 1,  0, 0,         1, 0);
        vecs[18] = mk(1, 0, 175,  0,        0, 0, 0,    0,        1, 0,  1, 'h3FFFF, 0, 0);

        idle_inputs();
        reset_n = 1'b0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        // Port-0 write pending through INIT; lands on the first RUN edge.
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = AW'(44); req0_wdata = 18'h0002C;
        reset_n = 1'b1;
        wait_init("init1");
        chk("held_req_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();

`ifndef MEM_BANK_ARB_INIT_FILL_EN
        do_write(0, 1717, 'h006B5);
        do_write(0, 10,   'h0000A);
        do_write(0, 20,   'h00014);
`endif

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_write = vecs[i].w0;
            req0_addr  = vecs[i].a0; req0_wdata = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_write = vecs[i].w1;
            req1_addr  = vecs[i].a1; req1_wdata = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].rdy0));
            chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].rdy1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].rv0));
            chk($sformatf("v%0d_rsp0_rdata", i), 32'(rsp0_rdata), 32'(vecs[i].rd0));
            chk($sformatf("v%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].rv1));
            chk($sformatf("v%0d_rsp1_rdata", i), 32'(rsp1_rdata), 32'(vecs[i].rd1));
        end
        @(negedge clk);
        idle_inputs();

        // Reset while a read response is on the outputs.
        @(negedge clk);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = AW'(175);
        @(posedge clk);
        #1;
        chk("inflight_valid", 32'(rsp0_valid), 32'd1);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        chk_reset_outputs("rst_run");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset again part-way through INIT (idx 500 in the fill build).
        repeat (500) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_init");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        wait_init("init2");

        do_read("rd175_after_rst", 175, EXP_175_AFTER_RESET);
        do_write(0, 3, 'h00055);
        do_read("rd3", 3, 18'h00055);
        do_read("rd44", 44, 18'h0002C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
